if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the fetch PC, drives a request/acknowledge instruction-memory port, and presents each fetched instruction as a one-cycle `running` pulse with its `PC` and `inst`. Handles branch redirects, including squashing an in-flight fetch, and back-pressure (`stall`) from the hazard unit by buffering one instruction.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- branch  in  1  redirect request from the execute stage, one-cycle pulse
- branch_target  in  32  redirect address; bits [1:0] are ignored and treated as 0
- stall  in  1  downstream cannot accept a new instruction this cycle
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address, stable while imem_req=1 and no ack
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle; allowed in the same cycle imem_req rises
- imem_rdata  in  32  instruction word
- running  out  1  registered; 1 for exactly one cycle per delivered instruction
- PC  out  32  registered; address of the delivered instruction
- inst  out  32  registered; delivered instruction word

## Operation

- Reset values: state=BOOT, running=0, PC=0, inst=0, imem_req=0, imem_addr=RESET_PC, redirect_pc=0, hold_pc=0, hold_inst=0.
- `running` defaults to 0 every cycle. PC/inst update only when running is set to 1 and otherwise hold their value.
- PC arithmetic: next address = imem_addr + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Priority: rst > branch > imem_ack > stall.
- States:
  - BOOT: imem_req=0, imem_ack ignored; next cycle go to REQ. A branch in BOOT loads imem_addr<=target.
  - REQ: imem_req=1.
    - branch with ack: discard rdata; imem_addr<=target; stay in REQ.
    - branch without ack: redirect_pc<=target; go to DROP. imem_addr is unchanged.
    - ack with stall: hold_pc<=imem_addr, hold_inst<=rdata, imem_addr<=+4; go to HOLD.
    - ack without stall: running<=1, PC<=imem_addr, inst<=rdata, imem_addr<=+4; stay in REQ.
  - HOLD: imem_req=0.
    - branch: drop the buffer, imem_addr<=target; go to REQ.
    - !stall: running<=1, PC<=hold_pc, inst<=hold_inst; go to REQ.
  - DROP: imem_req=1 with the old address, waiting to absorb the stale ack.
    - branch without ack: redirect_pc<=target (newest wins).
    - ack: discard rdata; imem_addr<=(branch ? target : redirect_pc); go to REQ.
- `running` is never set in a cycle where `branch`=1. The IF/ID register flushes on the same edge, so no wrong-path instruction reaches decode.
- `stall` is sampled only on an ack in REQ, or in HOLD. A stall arriving while running is already high does not revoke that delivery.

## Timing

- First request: imem_req=1 in the second cycle after rst deasserts (BOOT lasts one cycle).
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. Fetch-to-running latency is 1 cycle (running is high in the cycle after the ack).
- N-wait memory: one instruction per N+1 cycles.
- Branch redirect: with a zero-wait memory, the target is requested in the cycle after `branch`.
  - In DROP, the redirect costs the remaining wait of the outstanding fetch plus 1 cycle.
- HOLD to delivery: running=1 in the cycle after stall drops. REQ re-asserts in that same cycle.
- rst mid-operation (any state): the next cycle is BOOT with all reset values. Any pending ack is ignored.

## Test plan

- Reset then a zero-wait memory returning word=addr: running high every cycle from cycle 3 (cycle 1 = first cycle after rst deasserts). PC sequence is 0,4,8,12 with inst equal to PC.
- RESET_PC=32'hFFFF_FFF8, zero-wait: PC sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Memory with 2-cycle ack delay; pulse branch (target 32'h100) one cycle after a req to 32'h8. Required response:
  - the ack for 32'h8 is dropped and running stays 0;
  - the next imem_addr is 32'h100;
  - the next delivered PC is 32'h100.
- Second branch during DROP: first target 32'h40, second target 32'h80 before the stale ack. The refetch address is 32'h80.
- Assert stall on the ack for 32'h10 and hold it 3 cycles:
  - imem_req=0 during HOLD and running=0;
  - when stall drops, running pulses once with PC=32'h10;
  - fetching resumes at 32'h14.
- branch and stall together in HOLD, target 32'h200: the buffer is discarded, no running pulse, and the next req is to 32'h200. Assert rst during REQ: the next cycle shows imem_req=0, running=0, PC=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, talks req/ack to instruction memory,
// and hands one instruction per running pulse to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        running,
    output logic [31:0] PC,
    output logic [31:0] inst
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] redirect_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    logic [31:0] addr_next;
    logic [31:0] redirect_next;
    logic [31:0] hold_pc_next;
    logic [31:0] hold_inst_next;
    logic [31:0] pc_next;
    logic [31:0] inst_next;
    logic        running_next;

    logic [31:0] target;
    logic [31:0] seq_addr;

    // Instructions are word aligned, so the low target bits never reach the memory port.
    assign target   = branch_target & ~32'd3;
    assign seq_addr = imem_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            running     <= 1'b0;
            PC          <= 32'd0;
            inst        <= 32'd0;
            imem_addr   <= RESET_PC;
            redirect_pc <= 32'd0;
            hold_pc     <= 32'd0;
            hold_inst   <= 32'd0;
        end else begin
            state       <= state_next;
            running     <= running_next;
            PC          <= pc_next;
            inst        <= inst_next;
            imem_addr   <= addr_next;
            redirect_pc <= redirect_next;
            hold_pc     <= hold_pc_next;
            hold_inst   <= hold_inst_next;
        end
    end

    // Branch always outranks an ack, so a wrong-path word never sets running.
    always_comb begin
        state_next     = state;
        running_next   = 1'b0;
        pc_next        = PC;
        inst_next      = inst;
        addr_next      = imem_addr;
        redirect_next  = redirect_pc;
        hold_pc_next   = hold_pc;
        hold_inst_next = hold_inst;
        imem_req       = 1'b0;

        case (state)
            BOOT: begin
                state_next = REQ;
                if (branch) begin
                    addr_next = target;
                end
            end

            REQ: begin
                imem_req = 1'b1;
                if (branch) begin
                    if (imem_ack) begin
                        addr_next = target;
                    end else begin
                        redirect_next = target;
                        state_next    = DROP;
                    end
                end else if (imem_ack) begin
                    addr_next = seq_addr;
                    if (stall) begin
                        hold_pc_next   = imem_addr;
                        hold_inst_next = imem_rdata;
                        state_next     = HOLD;
                    end else begin
                        running_next = 1'b1;
                        pc_next      = imem_addr;
                        inst_next    = imem_rdata;
                    end
                end
            end

            HOLD: begin
                if (branch) begin
                    addr_next  = target;
                    state_next = REQ;
                end else if (!stall) begin
                    running_next = 1'b1;
                    pc_next      = hold_pc;
                    inst_next    = hold_inst;
                    state_next   = REQ;
                end
            end

            DROP: begin
                // Keep the stale request up until memory answers it, then refetch.
                imem_req = 1'b1;
                if (imem_ack) begin
                    addr_next  = branch ? target : redirect_pc;
                    state_next = REQ;
                end else if (branch) begin
                    redirect_next = target;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: scoreboard of expected delivered PCs
// against a req/ack memory model with programmable wait states.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        branch;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        running;
    logic [31:0] PC;
    logic [31:0] inst;

    logic        rst2;
    logic        branch2;
    logic [31:0] branch_target2;
    logic        stall2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        running2;
    logic [31:0] pc2;
    logic [31:0] inst2;

    int          num_checked = 0;
    int          num_failed  = 0;
    int          mem_wait    = 0;
    int          wait_cnt    = 0;
    bit          prev_req    = 1'b0;
    bit          prev_ack    = 1'b0;
    logic [31:0] exp_pc_q[$];

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .branch        (branch),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .running       (running),
        .PC            (PC),
        .inst          (inst)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk           (clk),
        .rst           (rst2),
        .branch        (branch2),
        .branch_target (branch_target2),
        .stall         (stall2),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_ack      (imem_ack2),
        .imem_rdata    (imem_rdata2),
        .running       (running2),
        .PC            (pc2),
        .inst          (inst2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checked++;
        if (observed !== expected) begin
            num_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic b, input logic [31:0] tgt, input logic s);
        branch        = b;
        branch_target = tgt;
        stall         = s;
    endtask

    task automatic waitReqAddr(input logic [31:0] a, input int budget);
        int n = 0;
        while (!(imem_req === 1'b1 && imem_addr === a) && n < budget) begin
            nextCycle();
            n++;
        end
        if (!(imem_req === 1'b1 && imem_addr === a))
            checkOutput("timeout_req_addr", imem_addr, a);
    endtask

    task automatic waitAddrChange(input logic [31:0] old_addr, input int budget);
        int n = 0;
        while (imem_addr === old_addr && n < budget) begin
            nextCycle();
            n++;
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_pc_q.size() != 0 && n < budget) begin
            nextCycle();
            n++;
        end
        if (exp_pc_q.size() != 0)
            checkOutput("timeout_drain", 32'(exp_pc_q.size()), 32'd0);
    endtask

    task automatic endTest();
        applyStimulus(1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("queue_empty", 32'(exp_pc_q.size()), 32'd0);
        exp_pc_q.delete();
    endtask

    // Memory answers a request after mem_wait extra cycles with a word derived from its address.
    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (prev_req && !prev_ack) wait_cnt = wait_cnt + 1;
            else                       wait_cnt = 0;
            imem_ack = (wait_cnt >= mem_wait);
        end else begin
            wait_cnt = 0;
            imem_ack = 1'b0;
        end
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        prev_req   = (imem_req === 1'b1);
        prev_ack   = imem_ack;
    end

    always @(negedge clk) begin
        imem_ack2   = (imem_req2 === 1'b1);
        imem_rdata2 = mem_word(imem_addr2);
    end

    // Scoreboard: every delivery must match the oldest expected PC.
    always @(negedge clk) begin
        if (running === 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                checkOutput("extra_delivery", 32'(running), 32'd0);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = exp_pc_q.pop_front();
                checkOutput("deliv_pc", PC, exp_pc);
                checkOutput("deliv_inst", inst, mem_word(exp_pc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        branch2 = 1'b0;
        branch_target2 = 32'd0;
        stall2 = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0);
        repeat (3) nextCycle();

        $display("[TB] reset values");
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_pc", PC, 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'd0);
        checkOutput("rst2_addr", imem_addr2, 32'hFFFF_FFF8);

        $display("[TB] zero-wait sequential fetch");
        mem_wait = 0;
        exp_pc_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        rst = 1'b0;
        checkOutput("boot_req", 32'(imem_req), 32'd0);
        nextCycle();
        checkOutput("first_req", 32'(imem_req), 32'd1);
        checkOutput("first_addr", imem_addr, 32'd0);
        nextCycle();
        checkOutput("first_running", 32'(running), 32'd1);
        waitDrain(20);
        rst = 1'b1;
        nextCycle();
        checkOutput("rst_mid_req", 32'(imem_req), 32'd0);
        checkOutput("rst_mid_running", 32'(running), 32'd0);
        checkOutput("rst_mid_pc", PC, 32'd0);
        endTest();

        $display("[TB] address wrap from FFFF_FFF8");
        rst2 = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("wrap_running", 32'(running2), 32'd1);
        checkOutput("wrap_pc0", pc2, 32'hFFFF_FFF8);
        checkOutput("wrap_inst0", inst2, mem_word(32'hFFFF_FFF8));
        nextCycle();
        checkOutput("wrap_pc1", pc2, 32'hFFFF_FFFC);
        nextCycle();
        checkOutput("wrap_pc2", pc2, 32'h0000_0000);
        checkOutput("wrap_inst2", inst2, mem_word(32'h0));
        rst2 = 1'b1;

        $display("[TB] branch with outstanding fetch");
        mem_wait = 2;
        exp_pc_q = '{32'h0, 32'h4, 32'h100};
        rst = 1'b0;
        waitReqAddr(32'h8, 40);
        nextCycle();
        applyStimulus(1'b1, 32'h100, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("drop_req", 32'(imem_req), 32'd1);
        checkOutput("drop_addr_hold", imem_addr, 32'h8);
        waitAddrChange(32'h8, 20);
        checkOutput("redirect_addr", imem_addr, 32'h100);
        checkOutput("redirect_running", 32'(running), 32'd0);
        waitDrain(30);
        endTest();

        $display("[TB] second branch during drop");
        mem_wait = 3;
        exp_pc_q = '{32'h0, 32'h4, 32'h80};
        rst = 1'b0;
        waitReqAddr(32'h8, 40);
        applyStimulus(1'b1, 32'h40, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h80, 1'b0);
        checkOutput("drop2_addr_hold", imem_addr, 32'h8);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        waitAddrChange(32'h8, 20);
        checkOutput("drop2_refetch", imem_addr, 32'h80);
        waitDrain(40);
        endTest();

        $display("[TB] stall on ack, hold three cycles");
        mem_wait = 0;
        exp_pc_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        rst = 1'b0;
        waitReqAddr(32'h10, 20);
        applyStimulus(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            if (i == 2) applyStimulus(1'b0, 32'd0, 1'b0);
            checkOutput("hold_req", 32'(imem_req), 32'd0);
            checkOutput("hold_running", 32'(running), 32'd0);
        end
        nextCycle();
        checkOutput("release_running", 32'(running), 32'd1);
        checkOutput("release_req", 32'(imem_req), 32'd1);
        checkOutput("release_addr", imem_addr, 32'h14);
        waitDrain(10);
        endTest();

        $display("[TB] branch and stall together in hold");
        mem_wait = 0;
        exp_pc_q = '{32'h0, 32'h4, 32'h200};
        rst = 1'b0;
        waitReqAddr(32'h8, 20);
        applyStimulus(1'b0, 32'd0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 32'h203, 1'b1);
        checkOutput("hb_hold_req", 32'(imem_req), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("hb_req", 32'(imem_req), 32'd1);
        checkOutput("hb_addr", imem_addr, 32'h200);
        checkOutput("hb_running", 32'(running), 32'd0);
        waitDrain(10);
        endTest();

        $display("[TB] branch coinciding with ack");
        mem_wait = 0;
        exp_pc_q = '{32'h0, 32'h4, 32'h300};
        rst = 1'b0;
        waitReqAddr(32'h8, 20);
        applyStimulus(1'b1, 32'h300, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("ba_running", 32'(running), 32'd0);
        checkOutput("ba_req", 32'(imem_req), 32'd1);
        checkOutput("ba_addr", imem_addr, 32'h300);
        waitDrain(10);
        endTest();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checked, num_failed);
        $finish;
    end

endmodule
